// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: FSM states and ALU select codes.
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_ADD = 2'd0;
  localparam logic [1:0] SEL_SUB = 2'd1;
  localparam logic [1:0] SEL_AND = 2'd2;
  localparam logic [1:0] SEL_OR  = 2'd3;

endpackage

// File: rtl/alu_sequencer_if.sv
// Start/operand/abort request and result bus between an issuer and the ALU sequencer.
interface alu_sequencer_if #(
  parameter int WIDTH = 4
);
  logic               i_w_start;
  logic [WIDTH-1:0]   i_w_op1;
  logic [WIDTH-1:0]   i_w_op2;
  logic               i_w_abort;
  logic               o_w_busy;
  logic [1:0]         o_w_sel;
  logic [WIDTH-1:0]   o_w_res;
  logic [1:0]         o_w_res_idx;
  logic               o_w_res_valid;
  logic [4*WIDTH-1:0] o_w_results;
  logic               o_w_done;

  modport master (
    output i_w_start, i_w_op1, i_w_op2, i_w_abort,
    input  o_w_busy, o_w_sel, o_w_res, o_w_res_idx, o_w_res_valid,
           o_w_results, o_w_done
  );

  modport slave (
    input  i_w_start, i_w_op1, i_w_op2, i_w_abort,
    output o_w_busy, o_w_sel, o_w_res, o_w_res_idx, o_w_res_valid,
           o_w_results, o_w_done
  );
endinterface

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU: add/sub modulo 2^WIDTH, bitwise and/or, chosen by sel.
module alu
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Operation select; carry and borrow are dropped by the result width
  always_comb begin
    y = '0;
    case (sel)
      SEL_ADD: y = a + b;
      SEL_SUB: y = a - b;
      SEL_AND: y = a & b;
      SEL_OR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Latches an operand pair on start, steps the ALU through all four operations
// with a programmable dwell, captures each result and pulses done at the end.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DWELL = 1
) (
  input  logic            i_w_clk,
  input  logic            i_w_reset_n,
  alu_sequencer_if.slave  bus
);

  localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

  state_t             state_r;
  logic [1:0]         sel_r;
  logic [3:0]         cnt_r;
  logic [WIDTH-1:0]   op1_r;
  logic [WIDTH-1:0]   op2_r;
  logic [WIDTH-1:0]   res_r;
  logic [1:0]         idx_r;
  logic               valid_r;
  logic               done_r;
  logic               busy_r;
  logic [4*WIDTH-1:0] results_r;
  logic [WIDTH-1:0]   alu_y_s;

  alu #(.WIDTH(WIDTH)) u_alu (
    .sel (sel_r),
    .a   (op1_r),
    .b   (op2_r),
    .y   (alu_y_s)
  );

  // Sequencer FSM with dwell counter and result capture registers
  always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
    if (!i_w_reset_n) begin
      state_r   <= ST_IDLE;
      sel_r     <= 2'd0;
      cnt_r     <= 4'd0;
      op1_r     <= '0;
      op2_r     <= '0;
      res_r     <= '0;
      idx_r     <= 2'd0;
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      results_r <= '0;
    end else begin
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // abort outranks start even though it has nothing to cancel here
          if (bus.i_w_start && !bus.i_w_abort) begin
            op1_r     <= bus.i_w_op1;
            op2_r     <= bus.i_w_op2;
            sel_r     <= SEL_ADD;
            cnt_r     <= 4'd0;
            results_r <= '0;
            busy_r    <= 1'b1;
            state_r   <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.i_w_abort) begin
            sel_r   <= 2'd0;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (cnt_r == CNT_LAST) begin
            results_r[sel_r*WIDTH +: WIDTH] <= alu_y_s;
            res_r   <= alu_y_s;
            idx_r   <= sel_r;
            valid_r <= 1'b1;
            cnt_r   <= 4'd0;
            if (sel_r == SEL_OR) begin
              sel_r   <= 2'd0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              sel_r   <= sel_r + 2'd1;
              state_r <= ST_RUN;
            end
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          sel_r   <= 2'd0;
          cnt_r   <= 4'd0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_w_busy      = busy_r;
  assign bus.o_w_sel       = sel_r;
  assign bus.o_w_res       = res_r;
  assign bus.o_w_res_idx   = idx_r;
  assign bus.o_w_res_valid = valid_r;
  assign bus.o_w_results   = results_r;
  assign bus.o_w_done      = done_r;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Sequential driver for the combinational `alu` block. It latches an operand pair on a start handshake and steps `sel` through all four ALU operations. Each ALU result is captured into a register and announced with a per-result valid pulse, then completion is signalled. It is the hardware-side issuer for the ALU interface, used for self-test and batch evaluation without a testbench driving `sel` by hand.

Parameters:
WIDTH, 4, operand/result width passed to the `alu` instance
DWELL, 1, cycles each `sel` value is held before the result is captured; legal range 1..15

Ports:
i_w_clk  input  1  clock, rising edge
i_w_reset_n  input  1  asynchronous active-low reset
i_w_start  input  1  start request, sampled only in IDLE
i_w_op1  input  WIDTH  operand 1, latched on accepted start
i_w_op2  input  WIDTH  operand 2, latched on accepted start
i_w_abort  input  1  synchronous abort, returns to IDLE
o_w_busy  output  1  high whenever state is not IDLE
o_w_sel  output  2  select currently driven to the ALU
o_w_res  output  WIDTH  most recently captured result
o_w_res_idx  output  2  `sel` value that produced `o_w_res`
o_w_res_valid  output  1  one-cycle pulse per captured result
o_w_results  output  4*WIDTH  all four results packed, slot k at bits [k*WIDTH +: WIDTH]
o_w_done  output  1  one-cycle pulse after the 4th capture

Behaviour:
- Reset (asynchronous, `i_w_reset_n`=0):
  - state=IDLE.
  - All outputs 0, including `o_w_results`, `o_w_sel`, the dwell counter and the latched operands.
  - Reset asserted mid-run discards the run immediately; no `done` pulse follows.
- ALU encoding used by the instance: sel 00 add, 01 sub, 10 and, 11 or.
  - Add and sub are modulo 2^WIDTH; carry and borrow are dropped.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on an edge with `i_w_start`=1:
    - latch op1 and op2;
    - sel=0, cnt=0;
    - clear `o_w_results` to 0;
    - go to RUN.
  - RUN, capture edge (cnt==DWELL-1):
    - `o_w_results` slot[sel] and `o_w_res` take the ALU output;
    - `o_w_res_idx`=sel, `o_w_res_valid`=1 for the following cycle only;
    - if sel==3 go to DONE, else sel+1 and cnt=0.
  - RUN, any other edge: cnt+1.
  - DONE: `o_w_done`=1 for exactly one cycle, then IDLE on the next edge.
- Latency: start accepted at edge E.
  - Result k is captured at edge E+(k+1)*DWELL.
  - `o_w_done` is high in the cycle after edge E+4*DWELL.
  - `o_w_busy` is high from E through the DONE cycle.
- The ALU is fed only from the latched operands. Changes on `i_w_op1`/`i_w_op2` during a run have no effect.
- `i_w_start` in RUN or DONE is ignored, not queued. Start held high continuously yields back-to-back runs with one IDLE cycle between them.
- `i_w_abort` in RUN or DONE: next edge goes to IDLE.
  - sel=0; no further valid or done pulses.
  - Already-captured slots keep their values.
  - Abort has priority over capture on the same edge.
  - Abort in IDLE has no effect, and abort has priority over start.
- `o_w_sel` is 0 in IDLE and DONE.
- `o_w_res` and `o_w_res_idx` hold their last value between pulses.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - ALU select constants SEL_ADD, SEL_SUB, SEL_AND, SEL_OR.
- One sub-module: the existing `alu`, instantiated once with WIDTH.
- The FSM, dwell counter and result registers stay in `alu_sequencer`.

Test Plan:
- DWELL=1, op1=4'h2, op2=4'h4, start pulse:
  - valid pulses on 4 consecutive cycles with (idx,res) = (0,6), (1,E), (2,0), (3,6);
  - done one cycle later; `o_w_results`=16'h60E6;
  - busy high for 5 cycles.
- DWELL=3, op1=4'hF, op2=4'h1:
  - captures 3 cycles apart with results 0, E, 1, F;
  - done at E+13; `o_w_sel` holds each value for 3 cycles.
- Start in IDLE, then change op1/op2 and pulse start again mid-run:
  - results match the originally latched operands;
  - exactly one done pulse.
- Abort asserted the cycle after the second valid pulse:
  - no further valid pulses and no done;
  - busy=0 next cycle; slots 0 and 1 retained, slots 2 and 3 equal 0.
- Assert `i_w_reset_n`=0 asynchronously mid-run (between edges):
  - all outputs 0 immediately;
  - after release, a fresh start runs normally.
- Start held high for 20 cycles with DWELL=1:
  - repeated runs, each 5 busy cycles followed by 1 idle cycle;
  - done count matches the number of runs.
